alu_packet_rx: RTL and testbench

//  Upstream front end for alu32: consumes the UART RX byte stream (valid/ready) and assembles
//  9-byte command packets into one alu32 request (opcode, operand A, operand B).

---
 rtl/alu_packet_rx.sv | 140 ++++++++++++++
 tb/tb_alu_packet_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_packet_rx.sv
// Assembles [hdr][A x N][B x N] UART bytes into one alu32 request; valid_o rises 1 cycle after last B byte.
// ready_o drops while a request is held for ready_i; ALU_PKT_ERRCNT_EN adds the saturating err_count_o port.
module alu_packet_rx #(
  parameter int OperandWidth  = 32,
  parameter int TimeoutCycles = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [7:0]              data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [1:0]              opcode_o,
  output logic [OperandWidth-1:0] operand_a_o,
  output logic [OperandWidth-1:0] operand_b_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    err_o
`ifdef ALU_PKT_ERRCNT_EN
  ,
  output logic [7:0]              err_count_o
`endif
);

  localparam int NB = OperandWidth / 8;
  localparam int IW = ($clog2(NB) > 3) ? $clog2(NB) : 3;
  localparam int TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {IDLE, OPA, OPB, SEND} state_e;

  state_e                  state_q;
  logic [IW-1:0]           idx_q;
  logic [TW-1:0]           tmo_q;
  logic [1:0]              opcode_q;
  logic [OperandWidth-1:0] opa_q;
  logic [OperandWidth-1:0] opb_q;
  logic                    valid_q;
  logic                    err_q;

  logic accept_d;
  logic last_d;
  logic tmo_hit_d;
  logic hdr_ok_d;

  assign ready_o   = (state_q != SEND);
  assign accept_d  = valid_i && ready_o;
  assign last_d    = (idx_q == IDX_LAST);
  assign tmo_hit_d = (TimeoutCycles > 0) && (tmo_q == TMO_LAST);
  assign hdr_ok_d  = (data_i[7:2] == 6'd0) && (data_i[1:0] != 2'd3);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tmo_q    <= '0;
      opcode_q <= 2'd0;
      opa_q    <= '0;
      opb_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (hdr_ok_d) begin
              opcode_q <= data_i[1:0];
              idx_q    <= '0;
              tmo_q    <= '0;
              state_q  <= OPA;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        OPA, OPB: begin
          if (accept_d) begin
            for (int i = 0; i < NB; i++) begin
              if (idx_q == IW'(i)) begin
                if (state_q == OPA) opa_q[8*i +: 8] <= data_i;
                else                opb_q[8*i +: 8] <= data_i;
              end
            end
            tmo_q <= '0;
            if (last_d) begin
              idx_q <= '0;
              if (state_q == OPA) begin
                state_q <= OPB;
              end else begin
                state_q <= SEND;
                valid_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else if (tmo_hit_d) begin
            // Stalled mid-packet: drop the partial operands and resync on the next header.
            state_q <= IDLE;
            err_q   <= 1'b1;
            idx_q   <= '0;
            tmo_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
          end else if (TimeoutCycles > 0) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        SEND: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign opcode_o    = opcode_q;
  assign operand_a_o = opa_q;
  assign operand_b_o = opb_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;

`ifdef ALU_PKT_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_cnt_q <= 8'd0;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_packet_rx.sv
// Scoreboard bench for alu_packet_rx built with a 16-cycle payload timeout.
module tb_alu_packet_rx;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  data_i = 8'h00;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  opcode_o;
  logic [31:0] operand_a_o;
  logic [31:0] operand_b_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        err_o;
`ifdef ALU_PKT_ERRCNT_EN
  logic [7:0]  err_count_o;
`endif

  alu_packet_rx #(.OperandWidth(32), .TimeoutCycles(16)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .opcode_o    (opcode_o),
    .operand_a_o (operand_a_o),
    .operand_b_o (operand_b_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .err_o       (err_o)
`ifdef ALU_PKT_ERRCNT_EN
    ,
    .err_count_o (err_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   err_seen    = 0;
  int   reqs        = 0;
  bit   rand_rdy    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Random ready_i changes just after the active edge so the monitor sees a settled value.
  always @(posedge clk_i) begin
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  end

  logic        prev_v = 1'b0, prev_hs = 1'b0, prev_rst = 1'b1;
  logic [1:0]  prev_op;
  logic [31:0] prev_a, prev_b;

  always @(negedge clk_i) begin
    exp_t e;
    #2;
    if (err_o) err_seen++;
    if (!reset_i && !prev_rst) begin
      if (prev_v && !prev_hs) begin
        check("vld_hold", {31'd0, valid_o}, 32'd1);
        check("op_hold", {30'd0, opcode_o}, {30'd0, prev_op});
        check("a_hold", operand_a_o, prev_a);
        check("b_hold", operand_b_o, prev_b);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("req_op", {30'd0, opcode_o}, {30'd0, e.op});
          check("req_a", operand_a_o, e.a);
          check("req_b", operand_b_o, e.b);
          reqs++;
        end
      end
    end
    prev_v   = valid_o;
    prev_hs  = valid_o && ready_i;
    prev_rst = reset_i;
    prev_op  = opcode_o;
    prev_a   = operand_a_o;
    prev_b   = operand_b_o;
  end

  // Called at a negedge; returns at the negedge following the accepting posedge, valid_i left high.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    data_i  = b;
    valid_i = 1'b1;
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("rdy_wait", {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
  endtask

  task automatic send_pkt(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push);
    exp_t e;
    e.op = op; e.a = a; e.b = b;
    if (push) exp_q.push_back(e);
    send_byte({6'd0, op});
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("rst_vld", {31'd0, valid_o}, 32'd0);
    check("rst_rdy", {31'd0, ready_o}, 32'd1);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_op", {30'd0, opcode_o}, 32'd0);
    check("rst_a", operand_a_o, 32'd0);
    check("rst_b", operand_b_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    repeat (3) @(negedge clk_i);
    pulse_reset();
    @(negedge clk_i);

    // 1: basic add, one-cycle request when ready_i is high
    send_pkt(2'd0, 32'd5, 32'd3, 1'b1);
    check("t1_lat_vld", {31'd0, valid_o}, 32'd1);
    check("t1_send_rdy", {31'd0, ready_o}, 32'd0);
    @(negedge clk_i);
    check("t1_vld_drop", {31'd0, valid_o}, 32'd0);
    check("t1_rdy_back", {31'd0, ready_o}, 32'd1);
    wait_drain();

    // 2: divide, stalled by ready_i with a pending byte that must not be consumed
    ready_i = 1'b0;
    send_pkt(2'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    data_i  = 8'h01;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_vld", {31'd0, valid_o}, 32'd1);
      check("t2_rdy_low", {31'd0, ready_o}, 32'd0);
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    send_pkt(2'd1, 32'h0000_0007, 32'h0000_0009, 1'b1);
    wait_drain();

    // 3: two bad headers then a good packet
    e0 = err_seen;
    send_byte(8'h07);
    send_byte(8'h83);
    valid_i = 1'b0;
    send_pkt(2'd0, 32'd5, 32'd3, 1'b1);
    wait_drain();
    check("t3_err_pulses", 32'(err_seen - e0), 32'd2);
    check("t3_reqs", 32'(reqs), 32'd4);
`ifdef ALU_PKT_ERRCNT_EN
    check("t3_err_count", {24'd0, err_count_o}, 32'd2);
`endif

    // 4: 16-cycle gap aborts, 15-cycle gap does not
    e0 = err_seen;
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h20);
    valid_i = 1'b0;
    repeat (15) @(negedge clk_i);
    check("t4_no_err_yet", {31'd0, err_o}, 32'd0);
    @(negedge clk_i);
    check("t4_tmo_err", {31'd0, err_o}, 32'd1);
    check("t4_tmo_rdy", {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
    send_pkt(2'd0, 32'd5, 32'd3, 1'b1);
    wait_drain();
    check("t4_err_once", 32'(err_seen - e0), 32'd1);
    e0 = err_seen;
    begin
      exp_t e;
      e.op = 2'd1; e.a = 32'h4030_2010; e.b = 32'd2;
      exp_q.push_back(e);
    end
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h20);
    valid_i = 1'b0;
    repeat (15) @(negedge clk_i);
    send_byte(8'h30);
    send_byte(8'h40);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    valid_i = 1'b0;
    wait_drain();
    check("t4_gap15_no_err", 32'(err_seen - e0), 32'd0);

    // 5: reset mid-packet and mid-SEND drops the request
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h44 - 8'(i));
    valid_i = 1'b0;
    pulse_reset();
    ready_i = 1'b0;
    send_pkt(2'd2, 32'h1122_3344, 32'h5566_7788, 1'b0);
    check("t5_vld_before_rst", {31'd0, valid_o}, 32'd1);
    pulse_reset();
    ready_i = 1'b1;
    @(negedge clk_i);
    check("t5_no_req", {31'd0, valid_o}, 32'd0);
    send_pkt(2'd1, 32'h8000_0001, 32'hDEAD_BEEF, 1'b1);
    wait_drain();

    // 6: back-to-back packets under random ready_i
    e0 = reqs;
    rand_rdy = 1'b1;
    send_pkt(2'd0, 32'h0102_0304, 32'hA0B0_C0D0, 1'b1);
    send_pkt(2'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    send_pkt(2'd2, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    wait_drain();
    rand_rdy = 1'b0;
    ready_i  = 1'b1;
    check("t6_reqs", 32'(reqs - e0), 32'd3);

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
